dm_stage: RTL and testbench

Memory-access stage of the P6 pipeline: owns the data memory, turns M-stage store operations into byte-enabled word writes and M-stage loads into a registered raw-word read, and carries the M/W pipeline register that feeds the W-stage load extender. Output is the unextended 32-bit word plus the address and MemOp needed to select and sign-extend the lane in W.

---
 rtl/dm_stage_pkg.sv | 52 +++++
 rtl/dm_stage_if.sv | 25 ++
 rtl/dm_stage_array.sv | 30 +++
 rtl/dm_stage.sv | 74 +++++++
 tb/tb_dm_stage.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/dm_stage_pkg.sv
// Shared MemOp encoding, default geometry and lane helpers for the memory-access stage.
package dm_stage_pkg;

  typedef enum logic [2:0] {
    MOP_NONE = 3'd0,
    MOP_LW   = 3'd1,
    MOP_LH   = 3'd2,
    MOP_LB   = 3'd3,
    MOP_SW   = 3'd4,
    MOP_SH   = 3'd5,
    MOP_SB   = 3'd6,
    MOP_RSV  = 3'd7
  } memop_e;

  localparam int DM_DEPTH = 3072;
  localparam int DM_AW    = 12;

  function automatic logic is_load(input logic [2:0] op);
    return (op == MOP_LW) || (op == MOP_LH) || (op == MOP_LB);
  endfunction

  function automatic logic is_store(input logic [2:0] op);
    return (op == MOP_SW) || (op == MOP_SH) || (op == MOP_SB);
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] op, input logic [1:0] a);
    case (op)
      MOP_SW:  return 4'b1111;
      MOP_SH:  return a[1] ? 4'b1100 : 4'b0011;
      MOP_SB:  return 4'b0001 << a;
      default: return 4'b0000;
    endcase
  endfunction

  // Replicate the store operand across lanes; byte enables pick the live ones.
  function automatic logic [31:0] lane_data(input logic [2:0] op, input logic [31:0] d);
    case (op)
      MOP_SH:  return {2{d[15:0]}};
      MOP_SB:  return {4{d[7:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] op, input logic [1:0] a);
    case (op)
      MOP_LW, MOP_SW: return a != 2'b00;
      MOP_LH, MOP_SH: return a[0];
      default:        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dm_stage_if.sv
// M-stage request and W-stage result bundle of the memory-access stage.
interface dm_stage_if;
  logic        m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [2:0]  m_memop;
  logic        w_valid;
  logic [31:0] w_pc;
  logic [31:0] w_addr;
  logic [2:0]  w_memop;
  logic [31:0] w_rdata;
  logic        w_exc_adel;
  logic        w_exc_ades;

  modport master (
    output m_valid, m_pc, m_addr, m_wdata, m_memop,
    input  w_valid, w_pc, w_addr, w_memop, w_rdata, w_exc_adel, w_exc_ades
  );

  modport slave (
    input  m_valid, m_pc, m_addr, m_wdata, m_memop,
    output w_valid, w_pc, w_addr, w_memop, w_rdata, w_exc_adel, w_exc_ades
  );
endinterface

// File: rtl/dm_stage_array.sv
// DEPTH x 32 data memory: synchronous clear, byte-enabled write, registered read
// (read data is 0 whenever the read enable is low).
module dm_array #(
  parameter int DEPTH = 3072,
  parameter int AW    = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] idx,
  input  logic [3:0]    we,
  input  logic [31:0]   wdata,
  input  logic          re,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rdata <= '0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (we[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
      rdata <= re ? mem[idx] : '0;
    end
  end

endmodule

// File: rtl/dm_stage.sv
// Memory-access stage: store lane/enable generation, range and alignment checks, M/W register.
// Optional alignment checking and address exceptions enabled by defining DM_ALIGN_CHECK_EN.
module dm_stage
  import dm_stage_pkg::*;
#(
  parameter int DEPTH = DM_DEPTH,
  parameter int AW    = DM_AW
) (
  input  logic       clk,
  input  logic       reset,
  dm_stage_if.slave  bus
);

  logic [AW-1:0] idx;
  logic          in_range;
  logic          ld;
  logic          st;
  logic          mis;
  logic [3:0]    we;
  logic          re;
  logic          adel_d;
  logic          ades_d;
  logic [31:0]   rdata;

  always_comb begin
    idx      = bus.m_addr[AW+1:2];
    in_range = bus.m_addr < 32'(DEPTH * 4);
    ld       = bus.m_valid && is_load(bus.m_memop);
    st       = bus.m_valid && is_store(bus.m_memop);
`ifdef DM_ALIGN_CHECK_EN
    mis      = misaligned(bus.m_memop, bus.m_addr[1:0]);
    adel_d   = ld && (mis || !in_range);
    ades_d   = st && (mis || !in_range);
`else
    mis      = 1'b0;
    adel_d   = 1'b0;
    ades_d   = 1'b0;
`endif
    // Faulting or out-of-range accesses neither write nor read.
    we = (st && in_range && !mis) ? byte_en(bus.m_memop, bus.m_addr[1:0]) : 4'b0000;
    re = ld && in_range && !mis;
  end

  dm_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk   (clk),
    .reset (reset),
    .idx   (idx),
    .we    (we),
    .wdata (lane_data(bus.m_memop, bus.m_wdata)),
    .re    (re),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.w_valid    <= 1'b0;
      bus.w_pc       <= '0;
      bus.w_addr     <= '0;
      bus.w_memop    <= '0;
      bus.w_exc_adel <= 1'b0;
      bus.w_exc_ades <= 1'b0;
    end else begin
      bus.w_valid    <= bus.m_valid;
      bus.w_pc       <= bus.m_pc;
      bus.w_addr     <= bus.m_addr;
      bus.w_memop    <= bus.m_memop;
      bus.w_exc_adel <= adel_d;
      bus.w_exc_ades <= ades_d;
    end
  end

  assign bus.w_rdata = rdata;

endmodule

// File: tb/tb_dm_stage.sv
// Bench for dm_stage: directed scenarios then random traffic against a word-array model.
module tb_dm_stage;

  localparam int DEPTH = 3072;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_fail = 0;

  logic [31:0] mdl [DEPTH];

  dm_stage_if bus();

  dm_stage #(.DEPTH(DEPTH), .AW(12)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // One M-stage slot: drive, predict from the model, clock, compare the W outputs.
  task automatic step(input logic rst, input logic v, input logic [2:0] op,
                      input logic [31:0] addr, input logic [31:0] wd);
    logic        ld, st, mis, inr;
    logic [31:0] e_rdata, old, mask, val;
    logic        e_adel, e_ades;
    int          w;
    @(negedge clk);
    reset       = rst;
    bus.m_valid = v;
    bus.m_pc    = $urandom;
    bus.m_addr  = addr;
    bus.m_wdata = wd;
    bus.m_memop = op;
    ld  = v && (op >= 3'd1) && (op <= 3'd3);
    st  = v && (op >= 3'd4) && (op <= 3'd6);
    inr = addr < DEPTH * 4;
    w   = int'(addr >> 2);
`ifdef DM_ALIGN_CHECK_EN
    mis = ((op == 3'd1 || op == 3'd4) && (addr % 4 != 0)) ||
          ((op == 3'd2 || op == 3'd5) && (addr % 2 != 0));
    e_adel = ld && (mis || !inr);
    e_ades = st && (mis || !inr);
`else
    mis = 1'b0;
    e_adel = 1'b0;
    e_ades = 1'b0;
`endif
    e_rdata = (ld && inr && !mis) ? mdl[w] : 32'h0;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mdl[i] = 32'h0;
    end else if (st && inr && !mis) begin
      old = mdl[w];
      case (op)
        3'd4: begin mask = 32'hFFFF_FFFF; val = wd; end
        3'd5: begin
          mask = 32'hFFFF << (16 * ((addr >> 1) % 2));
          val  = (wd & 32'hFFFF) << (16 * ((addr >> 1) % 2));
        end
        default: begin
          mask = 32'hFF << (8 * (addr % 4));
          val  = (wd & 32'hFF) << (8 * (addr % 4));
        end
      endcase
      mdl[w] = (old & ~mask) | val;
    end
    @(posedge clk);
    #1;
    chk("w_valid", 32'(bus.w_valid), rst ? 32'h0 : 32'(v));
    chk("w_pc",    bus.w_pc,   rst ? 32'h0 : bus.m_pc);
    chk("w_addr",  bus.w_addr, rst ? 32'h0 : addr);
    chk("w_memop", 32'(bus.w_memop), rst ? 32'h0 : 32'(op));
    chk("w_rdata", bus.w_rdata, rst ? 32'h0 : e_rdata);
    chk("w_adel",  32'(bus.w_exc_adel), rst ? 32'h0 : 32'(e_adel));
    chk("w_ades",  32'(bus.w_exc_ades), rst ? 32'h0 : 32'(e_ades));
  endtask

  initial begin
    logic [31:0] a;
    int          r;
    reset = 1'b1;
    bus.m_valid = 1'b0; bus.m_pc = '0; bus.m_addr = '0; bus.m_wdata = '0; bus.m_memop = '0;
    for (int i = 0; i < DEPTH; i++) mdl[i] = 32'h0;
    step(1'b1, 1'b0, 3'd0, 32'h0, 32'h0);

    // Reset behaviour, including a store presented while reset is high.
    step(1'b0, 1'b1, 3'd4, 32'h0,  32'hCAFE_F00D);
    step(1'b0, 1'b1, 3'd4, 32'h10, 32'h1111_2222);
    step(1'b1, 1'b1, 3'd4, 32'h20, 32'hDEAD_BEEF);
    step(1'b0, 1'b1, 3'd1, 32'h0,  32'h0);
    chk("rst_lw0", bus.w_rdata, 32'h0);
    step(1'b0, 1'b1, 3'd1, 32'h10, 32'h0);
    chk("rst_lw10", bus.w_rdata, 32'h0);
    step(1'b0, 1'b1, 3'd1, 32'h20, 32'h0);
    chk("rst_store_drop", bus.w_rdata, 32'h0);

    // Word store then load-back, then sub-word merge.
    step(1'b0, 1'b1, 3'd4, 32'h100, 32'h1234_5678);
    step(1'b0, 1'b1, 3'd1, 32'h100, 32'h0);
    chk("sw_lw", bus.w_rdata, 32'h1234_5678);
    step(1'b0, 1'b1, 3'd5, 32'h102, 32'h0000_BEEF);
    step(1'b0, 1'b1, 3'd6, 32'h101, 32'h0000_00AA);
    step(1'b0, 1'b1, 3'd1, 32'h100, 32'h0);
    chk("merge", bus.w_rdata, 32'hBEEF_AA78);

    // Out-of-range and last in-range word.
    step(1'b0, 1'b1, 3'd4, 32'h3000, 32'h5555_AAAA);
    step(1'b0, 1'b1, 3'd1, 32'h3000, 32'h0);
    step(1'b0, 1'b1, 3'd4, 32'h2FFC, 32'h7777_8888);
    step(1'b0, 1'b1, 3'd1, 32'h2FFC, 32'h0);
    chk("last_word", bus.w_rdata, 32'h7777_8888);
    step(1'b0, 1'b1, 3'd1, 32'h0, 32'h0);
    chk("oor_alias", bus.w_rdata, 32'h0);

    // Misaligned word store / halfword load.
    step(1'b0, 1'b1, 3'd4, 32'h102, 32'h0BAD_0BAD);
    step(1'b0, 1'b1, 3'd1, 32'h100, 32'h0);
`ifdef DM_ALIGN_CHECK_EN
    chk("misaligned_sw", bus.w_rdata, 32'hBEEF_AA78);
`else
    chk("misaligned_sw", bus.w_rdata, 32'h0BAD_0BAD);
`endif
    step(1'b0, 1'b1, 3'd2, 32'h101, 32'h0);

    // Bubble carrying a store must not write.
    step(1'b0, 1'b0, 3'd4, 32'h200, 32'hFFFF_FFFF);
    step(1'b0, 1'b1, 3'd1, 32'h200, 32'h0);
    chk("bubble_store", bus.w_rdata, 32'h0);

    // Random traffic concentrated on a small window plus range edges.
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 9);
      if (r < 7)      a = 32'h100 + $urandom_range(0, 63);
      else if (r < 9) a = 32'h2FF8 + $urandom_range(0, 15);
      else            a = $urandom;
      step(1'b0, ($urandom_range(0, 9) != 0), 3'($urandom_range(0, 7)), a, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
